digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry_if.sv | 20 ++
 rtl/digit_entry.sv | 135 +++++++++++++
 tb/tb_digit_entry.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/digit_entry_if.sv
// Keypad-side bundle for digit_entry: key strobe/code in, entered value and status out.
interface digit_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [13:0] number;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        busy;

  modport master (
    output key_valid, key_code,
    input  key_ready, number, digit_count, overflow, busy
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, number, digit_count, overflow, busy
  );
endinterface

// File: rtl/digit_entry.sv
// Decimal keypad entry: digits append in one cycle, backspace divides by 10
// with a 14-step restoring divider, clear aborts anything in flight.
module digit_entry #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  digit_entry_if.slave  bus
);

  typedef enum logic {IDLE, DIVIDE} state_t;

  localparam logic [2:0] LP_MAX       = 3'(MAX_DIGITS);
  localparam logic [3:0] LP_LAST_STEP = 4'd13;

  state_t      r_state,    w_state_nxt;
  logic [13:0] r_number,   w_number_nxt;
  logic [2:0]  r_count,    w_count_nxt;
  logic        r_overflow, w_overflow_nxt;
  logic [13:0] r_dividend, w_dividend_nxt;
  logic [12:0] r_quot,     w_quot_nxt;
  logic [3:0]  r_rem,      w_rem_nxt;
  logic [3:0]  r_step,     w_step_nxt;

  logic        w_key_digit;
  logic        w_key_bksp;
  logic        w_key_clear;
  logic [13:0] w_times10;
  logic [4:0]  w_trial;
  logic        w_qbit;
  logic [3:0]  w_rem_step;

  assign w_key_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign w_key_bksp  = bus.key_valid && (bus.key_code == 4'd10);
  assign w_key_clear = bus.key_valid && (bus.key_code == 4'd11);

  // number*10 + d as 8x + 2x + d; the digit-count limit keeps this below 10^MAX_DIGITS.
  assign w_times10 = {r_number[10:0], 3'b000} + {r_number[12:0], 1'b0} + {10'd0, bus.key_code};

  // One restoring-division step: remainder < 10 always fits in 4 bits.
  always_comb begin
    w_trial    = {r_rem, r_dividend[13]};
    w_qbit     = (w_trial >= 5'd10);
    w_rem_step = w_qbit ? 4'(w_trial - 5'd10) : w_trial[3:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_number   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_dividend <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_step     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_number   <= w_number_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_dividend <= w_dividend_nxt;
      r_quot     <= w_quot_nxt;
      r_rem      <= w_rem_nxt;
      r_step     <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_number_nxt   = r_number;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_dividend_nxt = r_dividend;
    w_quot_nxt     = r_quot;
    w_rem_nxt      = r_rem;
    w_step_nxt     = r_step;

    case (r_state)
      IDLE: begin
        if (w_key_clear) begin
          w_number_nxt   = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
        end else if (w_key_digit) begin
          if (r_count >= LP_MAX) begin
            w_overflow_nxt = 1'b1;
          end else if (!((bus.key_code == 4'd0) && (r_number == '0))) begin
            w_number_nxt = w_times10;
            w_count_nxt  = r_count + 3'd1;
          end
        end else if (w_key_bksp && (r_number != '0)) begin
          w_state_nxt    = DIVIDE;
          w_dividend_nxt = r_number;
          w_quot_nxt     = '0;
          w_rem_nxt      = '0;
          w_step_nxt     = '0;
        end
      end

      DIVIDE: begin
        if (w_key_clear) begin
          w_state_nxt    = IDLE;
          w_number_nxt   = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
          w_dividend_nxt = '0;
          w_quot_nxt     = '0;
          w_rem_nxt      = '0;
          w_step_nxt     = '0;
        end else begin
          w_dividend_nxt = {r_dividend[12:0], 1'b0};
          w_quot_nxt     = {r_quot[11:0], w_qbit};
          w_rem_nxt      = w_rem_step;
          w_step_nxt     = r_step + 4'd1;
          if (r_step == LP_LAST_STEP) begin
            w_state_nxt    = IDLE;
            w_number_nxt   = {r_quot, w_qbit};
            w_count_nxt    = r_count - 3'd1;
            w_overflow_nxt = 1'b0;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.key_ready   = (r_state == IDLE);
  assign bus.busy        = (r_state == DIVIDE);
  assign bus.number      = r_number;
  assign bus.digit_count = r_count;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_digit_entry.sv
// Directed and randomized checks of digit_entry against hand values and a decimal model.
module tb_digit_entry;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  int   m_num;
  int   m_cnt;
  int   m_ovf;
  int   m_busy;

  digit_entry_if bus ();

  digit_entry #(.MAX_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one key for one cycle; returns 1 time unit after the accepting edge.
  task automatic key(input int code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic kv, input int kc);
    if (m_busy > 0) begin
      if (kv && kc == 11) begin
        m_busy = 0; m_num = 0; m_cnt = 0; m_ovf = 0;
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_num = m_num / 10; m_cnt--; m_ovf = 0;
        end
      end
    end else if (kv) begin
      if (kc <= 9) begin
        if (m_cnt == 4) m_ovf = 1;
        else if (!(kc == 0 && m_num == 0)) begin
          m_num = m_num * 10 + kc; m_cnt++;
        end
      end else if (kc == 10) begin
        if (m_num != 0) m_busy = 14;
      end else if (kc == 11) begin
        m_num = 0; m_cnt = 0; m_ovf = 0;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    reset = 1'b0;
    #23;
    check("rst_number", int'(bus.number), 0);
    check("rst_count",  int'(bus.digit_count), 0);
    check("rst_ovf",    int'(bus.overflow), 0);
    check("rst_busy",   int'(bus.busy), 0);
    check("rst_ready",  int'(bus.key_ready), 1);
    @(negedge clk);
    reset = 1'b1;

    // 1,2,3,4 on consecutive cycles
    key(1); check("d1", int'(bus.number), 1);    check("d1_busy", int'(bus.busy), 0);
    key(2); check("d2", int'(bus.number), 12);   check("d2_busy", int'(bus.busy), 0);
    key(3); check("d3", int'(bus.number), 123);  check("d3_busy", int'(bus.busy), 0);
    key(4); check("d4", int'(bus.number), 1234); check("d4_busy", int'(bus.busy), 0);
    check("d4_count", int'(bus.digit_count), 4);
    key(13); check("ign13", int'(bus.number), 1234);

    // overflow at max digits, then backspace
    key(5);
    check("ovf_number", int'(bus.number), 1234);
    check("ovf_flag",   int'(bus.overflow), 1);
    check("ovf_count",  int'(bus.digit_count), 4);
    key(10);
    for (int i = 0; i < 14; i++) begin
      check("bs_busy",  int'(bus.busy), 1);
      check("bs_ready", int'(bus.key_ready), 0);
      check("bs_hold",  int'(bus.number), 1234);
      cycles(1);
    end
    check("bs_done_busy", int'(bus.busy), 0);
    check("bs_number",    int'(bus.number), 123);
    check("bs_count",     int'(bus.digit_count), 3);
    check("bs_ovf",       int'(bus.overflow), 0);

    // leading zeros, backspace to zero, backspace on zero
    key(11);
    check("clr_number", int'(bus.number), 0);
    check("clr_count",  int'(bus.digit_count), 0);
    key(0); check("lz0_count", int'(bus.digit_count), 0);
    key(0); check("lz1_number", int'(bus.number), 0);
    key(7);
    check("lz_number", int'(bus.number), 7);
    check("lz_count",  int'(bus.digit_count), 1);
    key(10);
    cycles(14);
    check("bs7_number", int'(bus.number), 0);
    check("bs7_count",  int'(bus.digit_count), 0);
    key(10);
    check("bs0_busy", int'(bus.busy), 0);
    cycles(1);
    check("bs0_busy2", int'(bus.busy), 0);

    // 9999: digit during divide ignored, clear aborts
    key(9); key(9); key(9); key(9);
    check("n9999", int'(bus.number), 9999);
    key(10);
    cycles(4);
    key(3);
    check("div_digit_num",  int'(bus.number), 9999);
    check("div_digit_busy", int'(bus.busy), 1);
    cycles(3);
    key(11);
    check("abort_number", int'(bus.number), 0);
    check("abort_busy",   int'(bus.busy), 0);
    check("abort_count",  int'(bus.digit_count), 0);
    cycles(10);
    check("abort_hold", int'(bus.number), 0);

    // async reset mid-division
    key(5); key(0); key(0); key(0);
    check("n5000", int'(bus.number), 5000);
    key(10);
    cycles(6);
    #2;
    reset = 1'b0;
    #1;
    check("arst_number", int'(bus.number), 0);
    check("arst_busy",   int'(bus.busy), 0);
    check("arst_ready",  int'(bus.key_ready), 1);
    check("arst_count",  int'(bus.digit_count), 0);
    @(negedge clk);
    reset = 1'b1;
    key(8);
    check("post_rst_number", int'(bus.number), 8);
    cycles(16);
    check("post_rst_hold", int'(bus.number), 8);
    check("post_rst_busy", int'(bus.busy), 0);

    // random keys against the decimal model
    key(11);
    m_num = 0; m_cnt = 0; m_ovf = 0; m_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      int   r;
      int   kc;
      logic kv;
      @(negedge clk);
      r  = int'($urandom_range(0, 19));
      kv = ($urandom_range(0, 3) != 0);
      if (r <= 9)       kc = r;
      else if (r <= 12) kc = 10;
      else if (r == 13) kc = 11;
      else              kc = 12 + (r - 14) % 4;
      bus.key_valid = kv;
      bus.key_code  = 4'(kc);
      @(posedge clk);
      model_step(kv, kc);
      #1;
      check("rnd_number", int'(bus.number), m_num);
      check("rnd_count",  int'(bus.digit_count), m_cnt);
      check("rnd_ovf",    int'(bus.overflow), m_ovf);
      check("rnd_busy",   int'(bus.busy), (m_busy > 0) ? 1 : 0);
      check("rnd_range",  (int'(bus.number) <= 9999) ? 1 : 0, 1);
    end
    bus.key_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
